// File: rtl/drain_pkg.sv
// Shared FSM encoding and fixed constants for the output BRAM drain.
// Read latency and the row-slot count are fixed properties of the output array and the drain buffer.
package drain_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } drain_state_t;

    localparam int NUM_BRAMS_DEF = 16;
    localparam int BANK_W        = $clog2(NUM_BRAMS_DEF);
    localparam int RD_LAT        = 1;
    localparam int ROW_SLOTS     = 2;
endpackage

// File: rtl/output_bram_drain_if.sv
// Serialized result stream: one signed word per valid/ready handshake, tagged with its source bank.
// The master holds data/bank/last stable while valid is high and ready is low.
interface output_bram_drain_if #(
    parameter int DW = 16
);
    logic signed [DW-1:0] m_data;
    logic [3:0]           m_bank;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;

    modport master (output m_data, m_bank, m_valid, m_last, input m_ready);
    modport slave  (input m_data, m_bank, m_valid, m_last, output m_ready);
endinterface

// File: rtl/drain_row_buffer.sv
// Two-entry ping-pong FIFO holding whole output rows; head is readable combinationally.
// Latency 1 from push to head visible; push while full and pop while empty are excluded by the caller.
module drain_row_buffer #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] slot_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            slot_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign head_dat = slot_q[rd_ptr_q];
    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
endmodule

// File: rtl/output_bram_drain.sv
// Reads output-array rows and serializes them bank by bank onto one valid/ready stream.
// First word 3 cycles after start; row reads stall while both row slots are committed.
module output_bram_drain
    import drain_pkg::*;
#(
    parameter int DW        = 16,
    parameter int NUM_BRAMS = 16,
    parameter int O_ADDR_W  = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [O_ADDR_W-1:0]           base_addr,
    input  logic [O_ADDR_W:0]             num_rows,
    output logic                          ext_read_mode,
    output logic [NUM_BRAMS*O_ADDR_W-1:0] ext_read_addr_flat,
    input  logic [NUM_BRAMS*DW-1:0]       ext_read_data_flat,
    output_bram_drain_if.master           m,
    output logic                          busy,
    output logic                          done
);
    localparam int ROWS_W = O_ADDR_W + 1;

    drain_state_t state_q, state_d;

    logic [O_ADDR_W-1:0]     base_q;
    logic [O_ADDR_W-1:0]     last_addr_q;
    logic [O_ADDR_W-1:0]     cur_addr;
    logic [O_ADDR_W-1:0]     rd_addr;
    logic [ROWS_W-1:0]       num_rows_q;
    logic [ROWS_W-1:0]       rows_issued_q;
    logic [ROWS_W-1:0]       rows_done_q;
    logic [RD_LAT-1:0]       rd_pipe_q;
    logic [BANK_W-1:0]       idx_q;
    logic [NUM_BRAMS*DW-1:0] head_dat;
    logic [2:0]              occupancy;
    logic [2:0]              pending;
    logic                    buf_full;
    logic                    buf_empty;
    logic                    start_acc;
    logic                    issue;
    logic                    stream_vld;
    logic                    hs;
    logic                    idx_last;
    logic                    row_is_last;
    logic                    pop;

    assign start_acc   = (state_q == IDLE) && start;
    assign occupancy   = buf_full ? 3'd2 : (buf_empty ? 3'd0 : 3'd1);
    assign pending     = occupancy + 3'($countones(rd_pipe_q));
    // A read is launched only if its capture slot is guaranteed free on arrival.
    assign issue       = (state_q == RUN) && (rows_issued_q < num_rows_q)
                         && (pending < 3'(ROW_SLOTS));
    assign cur_addr    = base_q + rows_issued_q[O_ADDR_W-1:0];
    assign rd_addr     = issue ? cur_addr : last_addr_q;
    assign ext_read_addr_flat = {NUM_BRAMS{rd_addr}};

    assign hs          = stream_vld && m.m_ready;
    assign idx_last    = (idx_q == BANK_W'(NUM_BRAMS - 1));
    assign row_is_last = (rows_done_q == num_rows_q - ROWS_W'(1));
    assign pop         = hs && idx_last;

    drain_row_buffer #(
        .W (NUM_BRAMS * DW)
    ) u_row_buffer (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_pipe_q[RD_LAT-1]),
        .push_dat (ext_read_data_flat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (buf_full),
        .empty    (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_rows == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (pop && row_is_last) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ext_read_mode = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        stream_vld    = 1'b0;
        unique case (state_q)
            RUN: begin
                ext_read_mode = 1'b1;
                busy          = 1'b1;
                stream_vld    = !buf_empty;
            end
            FINISH: begin
                ext_read_mode = 1'b1;
                done          = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q        <= '0;
            num_rows_q    <= '0;
            rows_issued_q <= '0;
            rows_done_q   <= '0;
            last_addr_q   <= '0;
            rd_pipe_q     <= '0;
            idx_q         <= '0;
        end else begin
            rd_pipe_q <= RD_LAT'({rd_pipe_q, issue});
            if (start_acc) begin
                base_q        <= base_addr;
                num_rows_q    <= num_rows;
                rows_issued_q <= '0;
                rows_done_q   <= '0;
                idx_q         <= '0;
            end else begin
                if (issue) begin
                    rows_issued_q <= rows_issued_q + ROWS_W'(1);
                    last_addr_q   <= cur_addr;
                end
                if (hs) begin
                    idx_q <= idx_last ? '0 : idx_q + BANK_W'(1);
                    if (idx_last) begin
                        rows_done_q <= rows_done_q + ROWS_W'(1);
                    end
                end
            end
        end
    end

    // Data is forced to zero while nothing is offered so idle/reset outputs read as 0.
    assign m.m_valid = stream_vld;
    assign m.m_data  = stream_vld ? head_dat[int'(idx_q)*DW +: DW] : '0;
    assign m.m_bank  = idx_q;
    assign m.m_last  = stream_vld && idx_last && row_is_last;
endmodule
